ledg_pwm_driver: RTL and testbench
==================================

// Module: ledg_pwm_driver
// PURPOSE
//  Downstream consumer of the green-LED PIO output port: drives the physical LEDG pins.
//  Applies a global PWM brightness and an optional blink to the raw PIO value.
//  Inputs are captured into shadow registers only at PWM period boundaries, so a
//  mid-period Nios write never produces a partial pulse. Single clock domain, same
//  clock as the PIO.
// PARAMETERS
//  WIDTH         9   number of LEDs (width of led_in / led_out)
//  PRESCALE      50  clk cycles per PWM tick, >= 1
//  PWM_BITS      4   PWM counter width; period = 2**PWM_BITS ticks
//  BLINK_PERIODS 8   PWM periods per blink half-phase, >= 1
// PORTS
//  clk           in   1         system clock
//  reset_n       in   1         asynchronous, active-low reset
//  led_in        in   WIDTH     LED pattern from PIO out_port
//  duty          in   PWM_BITS  brightness; 0 = off, all-ones = 100% on
//  blink_en      in   1         1 = blink enabled LEDs on/off
//  led_out       out  WIDTH     registered LED drive, 1 = LED lit
//  period_strobe out  1         1-cycle pulse in the cycle after shadows load
// BEHAVIOUR
//  Reset values
//   - reset_n low: all state clears asynchronously.
//   - pre_cnt=0, pwm_cnt=0, blink_cnt=0, blink_phase=1 (on).
//   - Shadow registers led_sh=0, duty_sh=0, blink_sh=0.
//   - Outputs led_out=0, period_strobe=0.
//  Prescaler
//   - pre_cnt counts 0..PRESCALE-1 and wraps.
//   - tick = (pre_cnt==PRESCALE-1).
//  PWM counter
//   - pwm_cnt increments on tick and wraps from 2**PWM_BITS-1 to 0.
//   - boundary = tick && pwm_cnt==2**PWM_BITS-1.
//  Boundary
//   - On a boundary clock edge: led_sh<=led_in, duty_sh<=duty, blink_sh<=blink_en.
//   - period_strobe is high for exactly the next cycle.
//   - Between boundaries, changes on led_in/duty/blink_en have no effect.
//  Blink
//   - blink_cnt counts boundaries 0..BLINK_PERIODS-1.
//   - At a boundary with blink_cnt==BLINK_PERIODS-1: blink_phase toggles, blink_cnt<=0.
//   - blink_cnt/blink_phase run even when blink_sh=0; blink_en only gates the output.
//  PWM enable
//   - pwm_on = (duty_sh == all-ones) || (pwm_cnt < duty_sh).
//   - duty_sh=0: never on. duty_sh=all-ones: always on (not 15/16).
//  Output
//   - led_out <= led_sh & {WIDTH{pwm_on && (!blink_sh || blink_phase)}}
//   - Latency: led_out reflects counter/shadow state one cycle late.
//   - A new pattern therefore first appears the cycle after period_strobe.
//  Start-up
//   - After reset, shadows stay 0 until the first boundary.
//   - led_out stays 0 for PRESCALE*2**PWM_BITS+1 cycles.
//  Reset mid-operation
//   - Immediate led_out=0; all counters restart from 0.
//   - Any pending shadow load is lost.
//  No handshake with the PIO: led_in is a level, sampled only at boundaries.
// TESTING  (PRESCALE=2, PWM_BITS=4, BLINK_PERIODS=2 -> period 32 clk)
//  1. Reset, led_in=9'h1FF, duty=15 -> led_out=0 and period_strobe=0 through cycle 32;
//     strobe pulses once at cycle 32; led_out=9'h1FF from cycle 33, constant thereafter.
//  2. led_in=9'h0A5, duty=4, blink_en=0 -> each period: led_out=9'h0A5 for 8 clk,
//     then 0 for 24 clk; duty=0 -> led_out stays 0.
//  3. Mid-period, change led_in 9'h0A5->9'h15A and duty 4->15 -> led_out keeps the old
//     pattern/duty until the cycle after the next period_strobe, then 9'h15A continuous.
//  4. blink_en=1, duty=15, led_in=9'h1FF -> led_out 9'h1FF for 64 clk, then 0 for 64 clk,
//     repeating; clearing blink_en mid-phase takes effect only at the next boundary.
//  5. Assert reset_n low for 1 cycle while led_out=9'h1FF -> led_out=0 asynchronously;
//     recovery behaves exactly as in test 1.
//  6. Check period_strobe spacing: exactly 32 clk between pulses, each 1 cycle wide,
//     over 10 periods with random led_in/duty changes.

Source files
------------

// File: rtl/ledg_pwm_driver_if.sv
// ---------------------------------------------------------------------------
// ledg_pwm_driver_if
//
// Bundles the signals between the green-LED PIO output port and the LEDG
// PWM driver.
//
// Protocol: there is no valid/ready handshake on this bundle. led_in, duty
// and blink_en are plain levels owned by the PIO side; the driver samples
// them only at PWM period boundaries. period_strobe is a single-cycle
// status pulse from the driver and needs no acknowledge.
//
// Signals
//   led_in        PIO -> driver  WIDTH     raw LED pattern from the PIO out_port
//   duty          PIO -> driver  PWM_BITS  global brightness (0 = off, all-ones = full)
//   blink_en      PIO -> driver  1         1 = blink the enabled LEDs
//   led_out       driver -> pins WIDTH     registered LED drive, 1 = lit
//   period_strobe driver -> PIO  1         pulse in the cycle after the shadows load
//
// Modports
//   master  the PIO / stimulus side (drives the levels, observes the outputs)
//   slave   the LEDG driver
// ---------------------------------------------------------------------------
interface ledg_pwm_driver_if #(
  parameter int WIDTH    = 9,
  parameter int PWM_BITS = 4
);

  logic [WIDTH-1:0]    led_in;
  logic [PWM_BITS-1:0] duty;
  logic                blink_en;
  logic [WIDTH-1:0]    led_out;
  logic                period_strobe;

  modport master (
    output led_in,
    output duty,
    output blink_en,
    input  led_out,
    input  period_strobe
  );

  modport slave (
    input  led_in,
    input  duty,
    input  blink_en,
    output led_out,
    output period_strobe
  );

endinterface : ledg_pwm_driver_if

// File: rtl/ledg_pwm_driver.sv
// ---------------------------------------------------------------------------
// ledg_pwm_driver
//
// Drives the physical LEDG pins from the green-LED PIO output port. A global
// PWM brightness and an optional blink are applied to the raw PIO pattern.
//
// The PIO inputs are copied into shadow registers only on the clock edge that
// ends a PWM period, so a Nios write landing mid-period can never produce a
// truncated or stretched pulse: the whole period is rendered from one
// consistent snapshot of pattern, duty and blink enable.
//
// Timing chain:
//   pre_cnt   0..PRESCALE-1, tick when it reaches PRESCALE-1
//   pwm_cnt   advances on tick, wraps 2**PWM_BITS-1 -> 0
//   boundary  tick while pwm_cnt is at its last value
//   blink     blink_cnt counts boundaries; every BLINK_PERIODS boundaries
//             blink_phase toggles
//
// Ports
//   clk      in  system clock (same clock as the PIO)
//   reset_n  in  asynchronous, active-low reset; clears every register
//   pio      slave modport of ledg_pwm_driver_if
//              led_in / duty / blink_en    levels, sampled at boundaries
//              led_out                     registered LED drive
//              period_strobe               1-cycle pulse after the shadows load
//
// Parameters
//   WIDTH          number of LEDs
//   PRESCALE       clk cycles per PWM tick (>= 1)
//   PWM_BITS       PWM counter width, period = 2**PWM_BITS ticks
//   BLINK_PERIODS  PWM periods per blink half-phase (>= 1)
// ---------------------------------------------------------------------------
module ledg_pwm_driver #(
  parameter int WIDTH         = 9,
  parameter int PRESCALE      = 50,
  parameter int PWM_BITS      = 4,
  parameter int BLINK_PERIODS = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ledg_pwm_driver_if.slave       pio
);

  // Counter widths. A count range of one value still needs a 1-bit register,
  // hence the guard around $clog2.
  localparam int PRE_W   = (PRESCALE > 1)      ? $clog2(PRESCALE)      : 1;
  localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [PRE_W-1:0]    PRE_MAX   = PRE_W'(PRESCALE - 1);
  localparam logic [BLINK_W-1:0]  BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;   // 1 = on half of the blink cycle

  logic [WIDTH-1:0]    r_led_sh;
  logic [PWM_BITS-1:0] r_duty_sh;
  logic                r_blink_sh;

  logic [WIDTH-1:0]    r_led_out;
  logic                r_period_strobe;

  // -------------------------------------------------------------------------
  // Combinational decode of the counter state
  // -------------------------------------------------------------------------
  logic w_tick;
  logic w_boundary;
  logic w_blink_wrap;
  logic w_pwm_on;
  logic w_blink_gate;
  logic w_drive;

  assign w_tick       = (r_pre_cnt == PRE_MAX);
  assign w_boundary   = w_tick && (r_pwm_cnt == PWM_MAX);
  assign w_blink_wrap = (r_blink_cnt == BLINK_MAX);

  // All-ones duty is treated as fully on rather than (2**N-1)/2**N, so the
  // PIO can request a steady LED without a one-tick gap every period.
  assign w_pwm_on     = (r_duty_sh == PWM_MAX) || (r_pwm_cnt < r_duty_sh);

  // Blink only masks the output when the snapshot enabled it; the blink
  // counters keep running regardless so the phase stays periodic.
  assign w_blink_gate = !r_blink_sh || r_blink_phase;
  assign w_drive      = w_pwm_on && w_blink_gate;

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // PWM counter: free-running modulo 2**PWM_BITS, so the wrap is implicit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Blink counter and phase. Phase starts "on" so a blinking pattern lights
  // immediately after the first boundary.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_boundary) begin
      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= !r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shadow registers: the only place the PIO levels are sampled.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_sh   <= '0;
      r_duty_sh  <= '0;
      r_blink_sh <= 1'b0;
    end else if (w_boundary) begin
      r_led_sh   <= pio.led_in;
      r_duty_sh  <= pio.duty;
      r_blink_sh <= pio.blink_en;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. led_out is computed from the pre-edge counter and shadow state,
  // so a freshly loaded snapshot first reaches the pins one cycle after the
  // load edge, i.e. in the cycle following period_strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_out       <= '0;
      r_period_strobe <= 1'b0;
    end else begin
      r_led_out       <= r_led_sh & {WIDTH{w_drive}};
      r_period_strobe <= w_boundary;
    end
  end

  assign pio.led_out       = r_led_out;
  assign pio.period_strobe = r_period_strobe;

endmodule : ledg_pwm_driver

// File: tb/tb_ledg_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_ledg_pwm_driver
//
// Bench for ledg_pwm_driver with PRESCALE=2, PWM_BITS=4, BLINK_PERIODS=2
// (PWM period = 32 clk). A reference model derives every expected output
// from the number of clock edges since reset: the PWM position, the number
// of elapsed boundaries and the blink phase all follow from plain division.
// ---------------------------------------------------------------------------
module tb_ledg_pwm_driver;

  localparam int WIDTH         = 9;
  localparam int PRESCALE      = 2;
  localparam int PWM_BITS      = 4;
  localparam int BLINK_PERIODS = 2;
  localparam int STEPS         = 1 << PWM_BITS;
  localparam int PERIOD        = PRESCALE * STEPS;
  localparam int DUTY_FULL     = STEPS - 1;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  logic [WIDTH-1:0]    led_in   = '0;
  logic [PWM_BITS-1:0] duty     = '0;
  logic                blink_en = 1'b0;

  ledg_pwm_driver_if #(.WIDTH(WIDTH), .PWM_BITS(PWM_BITS)) pio ();

  assign pio.led_in   = led_in;
  assign pio.duty     = duty;
  assign pio.blink_en = blink_en;

  ledg_pwm_driver #(
    .WIDTH        (WIDTH),
    .PRESCALE     (PRESCALE),
    .PWM_BITS     (PWM_BITS),
    .BLINK_PERIODS(BLINK_PERIODS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pio    (pio)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: t = clock edges since reset release.
  // -------------------------------------------------------------------------
  int               t = 0;
  logic [WIDTH-1:0] m_led   = '0;
  int               m_duty  = 0;
  bit               m_blink = 1'b0;
  bit               exp_strobe = 1'b0;

  task automatic model_reset();
    t          = 0;
    m_led      = '0;
    m_duty     = 0;
    m_blink    = 1'b0;
    exp_strobe = 1'b0;
    exp_q.delete();
  endtask

  // Called at each rising edge; inputs are stable there.
  task automatic model_edge();
    int  tp;
    int  pwm_pos;
    int  n_bound;
    bit  phase_on;
    bit  lit;
    tp       = t;                           // state before this edge
    pwm_pos  = (tp / PRESCALE) % STEPS;
    n_bound  = tp / PERIOD;                 // boundaries already taken
    phase_on = ((n_bound / BLINK_PERIODS) % 2) == 0;
    lit      = ((m_duty == DUTY_FULL) || (pwm_pos < m_duty)) && (!m_blink || phase_on);
    exp_q.push_back(lit ? m_led : '0);
    t = tp + 1;
    exp_strobe = (t % PERIOD) == 0;
    if (exp_strobe) begin
      m_led   = led_in;
      m_duty  = int'(duty);
      m_blink = blink_en;
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic cyc();
    logic [WIDTH-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("model_led_out", 32'(pio.led_out), 32'(e));
    check("model_strobe", 32'(pio.period_strobe), 32'(exp_strobe));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("async_led_clear", 32'(pio.led_out), 32'h0);
    check("async_strobe_clear", 32'(pio.period_strobe), 32'h0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic wait_strobe();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      cyc();
      if (pio.period_strobe) found = 1'b1;
    end
    check("strobe_timeout", 32'(found), 32'h1);
  endtask

  // Reset recovery with led_in=1FF, duty=full.
  task automatic startup_check(input string tag);
    for (int c = 1; c <= PERIOD + 8; c++) begin
      cyc();
      check({tag, "_strobe"}, 32'(pio.period_strobe), 32'(c == PERIOD));
      check({tag, "_led"}, 32'(pio.led_out), (c >= PERIOD + 1) ? 32'h1FF : 32'h0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector table: steady patterns, lit cycles counted over one period.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0]    led;
    logic [PWM_BITS-1:0] duty;
    int                  exp_on;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int on_cnt;
    int other_cnt;
    int last_strobe;
    bit prev_strobe;

    vecs[0] = '{led: 9'h1FF, duty: 4'd15, exp_on: 32};
    vecs[1] = '{led: 9'h0A5, duty: 4'd4,  exp_on: 8};
    vecs[2] = '{led: 9'h0A5, duty: 4'd0,  exp_on: 0};
    vecs[3] = '{led: 9'h15A, duty: 4'd1,  exp_on: 2};
    vecs[4] = '{led: 9'h0F0, duty: 4'd8,  exp_on: 16};
    vecs[5] = '{led: 9'h101, duty: 4'd14, exp_on: 28};

    // Test 1: start-up
    led_in = 9'h1FF; duty = 4'd15; blink_en = 1'b0;
    #1;
    check("reset_led", 32'(pio.led_out), 32'h0);
    check("reset_strobe", 32'(pio.period_strobe), 32'h0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    startup_check("startup");

    // Test 2: table of steady patterns
    foreach (vecs[i]) begin
      led_in = vecs[i].led;
      duty   = vecs[i].duty;
      wait_strobe();
      on_cnt = 0;
      other_cnt = 0;
      for (int c = 0; c < PERIOD; c++) begin
        cyc();
        if (pio.led_out == vecs[i].led) on_cnt++;
        else if (pio.led_out != '0) other_cnt++;
      end
      check("table_on_cycles", 32'(on_cnt), 32'(vecs[i].exp_on));
      check("table_stray_value", 32'(other_cnt), 32'h0);
    end

    // Test 3: mid-period change is deferred to the next boundary
    led_in = 9'h0A5; duty = 4'd4;
    wait_strobe();
    for (int k = 1; k <= 3; k++) cyc();
    led_in = 9'h15A; duty = 4'd15;
    for (int k = 4; k <= PERIOD; k++) begin
      cyc();
      check("midchg_old", 32'(pio.led_out), (k <= 8) ? 32'h0A5 : 32'h0);
    end
    check("midchg_strobe", 32'(pio.period_strobe), 32'h1);
    for (int k = 1; k <= PERIOD; k++) begin
      cyc();
      check("midchg_new", 32'(pio.led_out), 32'h15A);
    end

    // Test 4: blink from reset, then disable mid off-phase
    led_in = 9'h1FF; duty = 4'd15; blink_en = 1'b1;
    do_reset();
    while (t < 200) begin
      cyc();
      if (t >= 33 && t <= 64)        check("blink_on1", 32'(pio.led_out), 32'h1FF);
      else if (t >= 65 && t <= 128)  check("blink_off1", 32'(pio.led_out), 32'h0);
      else if (t >= 129 && t <= 192) check("blink_on2", 32'(pio.led_out), 32'h1FF);
      else if (t >= 193)             check("blink_off2", 32'(pio.led_out), 32'h0);
    end
    blink_en = 1'b0;
    while (t < 240) begin
      cyc();
      check("blink_clear", 32'(pio.led_out), (t >= 225) ? 32'h1FF : 32'h0);
    end

    // Test 5: reset while lit, recovery identical to start-up
    check("pre_reset_lit", 32'(pio.led_out), 32'h1FF);
    do_reset();
    startup_check("recover");

    // Test 6: strobe spacing under random input changes
    last_strobe = -1;
    prev_strobe = 1'b0;
    for (int c = 0; c < 10 * PERIOD + 2; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        led_in   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        duty     = PWM_BITS'($urandom_range(0, DUTY_FULL));
        blink_en = 1'($urandom_range(0, 1));
      end
      cyc();
      if (prev_strobe) check("strobe_width", 32'(pio.period_strobe), 32'h0);
      if (pio.period_strobe) begin
        if (last_strobe >= 0) check("strobe_spacing", 32'(t - last_strobe), 32'(PERIOD));
        last_strobe = t;
      end
      prev_strobe = pio.period_strobe;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ledg_pwm_driver
